// File: rtl/router_pkg.sv
// Shared definitions for the 5-port mesh-router switch allocator: port indices,
// idle select code, flit layout and the round-robin pointer advance.
package router_pkg;

    localparam int NPORTS = 5;

    localparam int P_N = 0;
    localparam int P_S = 1;
    localparam int P_E = 2;
    localparam int P_W = 3;
    localparam int P_L = 4;

    localparam logic [2:0] SEL_NONE = 3'd7;

    localparam int COORD_W_DEF = 3;

    // Header flit layout: {dest_x, dest_y} in the low bits of a 10-bit flit
    localparam int FLIT_W     = 10;
    localparam int HDR_DY_LSB = 0;
    localparam int HDR_DX_LSB = COORD_W_DEF;

    function automatic logic [2:0] rr_next(input logic [2:0] idx);
        return (idx >= 3'(P_L)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arb5.sv
// Combinational 5-way round-robin arbiter: first requester at or after ptr,
// scanning upward modulo 5.
module rr_arb5
    import router_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [2:0]        ptr,
    output logic [2:0]        grant,
    output logic              any_grant
);

    logic [2:0] idx;

    always_comb begin
        grant     = SEL_NONE;
        any_grant = 1'b0;
        idx       = 3'd0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = 3'((int'(ptr) + k) % NPORTS);
            if (!any_grant && req[idx]) begin
                grant     = idx;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_switch_alloc.sv
// Switch allocator for a 5-port XY-routed mesh router: routes each input,
// arbitrates per output, and holds the crossbar select until downstream accepts.
module router_switch_alloc
    import router_pkg::*;
#(
    parameter int MY_X    = 1,
    parameter int MY_Y    = 1,
    parameter int COORD_W = COORD_W_DEF
)
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NPORTS-1:0]               in_valid,
    input  logic [NPORTS*2*COORD_W-1:0]     in_dest,
    output logic [NPORTS-1:0]               in_ready,
    input  logic [NPORTS-1:0]               out_ready,
    output logic [NPORTS-1:0]               out_valid,
    output logic [NPORTS*3-1:0]             xbar_sel
);

    localparam logic [COORD_W-1:0] MX = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY = COORD_W'(MY_Y);

    logic [2:0]        route     [NPORTS];
    logic [NPORTS-1:0] req       [NPORTS];
    logic [2:0]        grant     [NPORTS];
    logic [NPORTS-1:0] any_grant;
    logic [2:0]        sel_q     [NPORTS];
    logic [2:0]        ptr_q     [NPORTS];

    // Dimension-ordered routing: resolve X fully before moving in Y
    function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dx,
                                            input logic [COORD_W-1:0] dy);
        if (dx > MX)      return 3'(P_E);
        else if (dx < MX) return 3'(P_W);
        else if (dy > MY) return 3'(P_N);
        else if (dy < MY) return 3'(P_S);
        else              return 3'(P_L);
    endfunction

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            route[i] = xy_route(in_dest[i*2*COORD_W + COORD_W +: COORD_W],
                                in_dest[i*2*COORD_W +: COORD_W]);
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                req[o][i] = in_valid[i] && (route[i] == 3'(o));
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rr_arb5 u_arb (
            .req       (req[o]),
            .ptr       (ptr_q[o]),
            .grant     (grant[o]),
            .any_grant (any_grant[o])
        );
    end

    // out_valid doubles as the per-output LOCKED flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            for (int o = 0; o < NPORTS; o++) begin
                sel_q[o] <= SEL_NONE;
                ptr_q[o] <= 3'd0;
            end
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (out_valid[o]) begin
                    if (out_ready[o]) begin
                        out_valid[o] <= 1'b0;
                        sel_q[o]     <= SEL_NONE;
                    end
                end else if (any_grant[o]) begin
                    out_valid[o] <= 1'b1;
                    sel_q[o]     <= grant[o];
                    ptr_q[o]     <= rr_next(grant[o]);
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            xbar_sel[o*3 +: 3] = sel_q[o];
        end
    end

    // Each input routes to exactly one output, so at most one output can ack it
    always_comb begin
        in_ready = '0;
        if (rst_n) begin
            for (int o = 0; o < NPORTS; o++) begin
                for (int i = 0; i < NPORTS; i++) begin
                    if (out_valid[o] && out_ready[o] && sel_q[o] == 3'(i)) begin
                        in_ready[i] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_router_switch_alloc.sv
// Directed self-checking bench for router_switch_alloc at MY_X=1, MY_Y=1.
module tb_router_switch_alloc;

    logic        clk;
    logic        rst_n;
    logic [4:0]  in_valid;
    logic [29:0] in_dest;
    logic [4:0]  in_ready;
    logic [4:0]  out_ready;
    logic [4:0]  out_valid;
    logic [14:0] xbar_sel;

    int checks;
    int failures;

    router_switch_alloc #(.MY_X(1), .MY_Y(1), .COORD_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .xbar_sel  (xbar_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream must hold a flit valid while its output is locked on it
    always @(negedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < 5; o++) begin
                if (out_valid[o] && xbar_sel[o*3 +: 3] < 3'd5) begin
                    assert (in_valid[xbar_sel[o*3 +: 3]])
                    else $error("protocol violation: input dropped valid while output %0d locked", o);
                end
            end
        end
    end

    function automatic logic [2:0] sel_of(input int o);
        return xbar_sel[o*3 +: 3];
    endfunction

    task automatic set_dest(input int i, input logic [2:0] x, input logic [2:0] y);
        in_dest[i*6 +: 6] = {x, y};
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 5'h1F;
        out_ready = 5'h1F;
        #1;
        checks++;
        if (in_ready !== 5'b0) begin
            failures++;
            $display("FAIL reset_in_ready_pre got=%b exp=%b", in_ready, 5'b0);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (out_valid !== 5'b0) begin
                failures++;
                $display("FAIL reset_out_valid[%0d] got=%b exp=%b", c, out_valid, 5'b0);
            end
            checks++;
            if (xbar_sel !== 15'h7FFF) begin
                failures++;
                $display("FAIL reset_xbar_sel[%0d] got=%h exp=%h", c, xbar_sel, 15'h7FFF);
            end
            checks++;
            if (in_ready !== 5'b0) begin
                failures++;
                $display("FAIL reset_in_ready[%0d] got=%b exp=%b", c, in_ready, 5'b0);
            end
        end
        in_valid  = 5'b0;
        out_ready = 5'b0;
        rst_n     = 1'b1;
    endtask

    task automatic test_single();
        set_dest(0, 3'd3, 3'd1);
        in_valid  = 5'b00001;
        out_ready = 5'b00100;
        #1;
        checks++;
        if (in_ready !== 5'b0) begin
            failures++;
            $display("FAIL single_in_ready_pre got=%b exp=%b", in_ready, 5'b0);
        end
        tick();
        checks++;
        if (out_valid !== 5'b00100) begin
            failures++;
            $display("FAIL single_out_valid got=%b exp=%b", out_valid, 5'b00100);
        end
        checks++;
        if (sel_of(2) !== 3'd0) begin
            failures++;
            $display("FAIL single_sel_e got=%0d exp=%0d", sel_of(2), 0);
        end
        checks++;
        if (in_ready !== 5'b00001) begin
            failures++;
            $display("FAIL single_in_ready got=%b exp=%b", in_ready, 5'b00001);
        end
        tick();
        in_valid = 5'b0;
        #1;
        checks++;
        if (out_valid !== 5'b0 || xbar_sel !== 15'h7FFF) begin
            failures++;
            $display("FAIL single_release got=%b/%h exp=%b/%h", out_valid, xbar_sel, 5'b0, 15'h7FFF);
        end
        checks++;
        if (in_ready !== 5'b0) begin
            failures++;
            $display("FAIL single_in_ready_after got=%b exp=%b", in_ready, 5'b0);
        end
        out_ready = 5'b0;
    endtask

    task automatic test_contention();
        logic [2:0] order [3];
        order[0] = 3'd0;
        order[1] = 3'd1;
        order[2] = 3'd3;
        set_dest(0, 3'd1, 3'd1);
        set_dest(1, 3'd1, 3'd1);
        set_dest(3, 3'd1, 3'd1);
        set_dest(4, 3'd1, 3'd1);
        in_valid  = 5'b01011;
        out_ready = 5'b10000;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 5'b10000 || sel_of(4) !== order[k]) begin
                failures++;
                $display("FAIL contention_grant[%0d] got=%b/%0d exp=%b/%0d", k, out_valid, sel_of(4), 5'b10000, order[k]);
            end
            checks++;
            if (in_ready !== 5'(1 << order[k])) begin
                failures++;
                $display("FAIL contention_in_ready[%0d] got=%b exp=%b", k, in_ready, 5'(1 << order[k]));
            end
            tick();
            checks++;
            if (out_valid !== 5'b0) begin
                failures++;
                $display("FAIL contention_idle[%0d] got=%b exp=%b", k, out_valid, 5'b0);
            end
        end
        // With the pointer at 4, L beats N
        in_valid = 5'b10001;
        tick();
        checks++;
        if (sel_of(4) !== 3'd4 || in_ready !== 5'b10000) begin
            failures++;
            $display("FAIL contention_ptr_end got=%0d/%b exp=%0d/%b", sel_of(4), in_ready, 4, 5'b10000);
        end
        tick();
        in_valid  = 5'b0;
        out_ready = 5'b0;
        #1;
        checks++;
        if (out_valid !== 5'b0) begin
            failures++;
            $display("FAIL contention_final_idle got=%b exp=%b", out_valid, 5'b0);
        end
    endtask

    task automatic test_backpressure();
        set_dest(0, 3'd3, 3'd1);
        in_valid  = 5'b00001;
        out_ready = 5'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 5'b00100 || sel_of(2) !== 3'd0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%b/%0d exp=%b/%0d", c, out_valid, sel_of(2), 5'b00100, 0);
            end
            checks++;
            if (in_ready !== 5'b0) begin
                failures++;
                $display("FAIL bp_in_ready[%0d] got=%b exp=%b", c, in_ready, 5'b0);
            end
            tick();
        end
        out_ready = 5'b00100;
        #1;
        checks++;
        if (in_ready !== 5'b00001) begin
            failures++;
            $display("FAIL bp_pulse_in_ready got=%b exp=%b", in_ready, 5'b00001);
        end
        tick();
        in_valid  = 5'b0;
        out_ready = 5'b0;
        #1;
        checks++;
        if (out_valid !== 5'b0 || sel_of(2) !== 3'd7) begin
            failures++;
            $display("FAIL bp_release got=%b/%0d exp=%b/%0d", out_valid, sel_of(2), 5'b0, 7);
        end
    endtask

    task automatic test_parallel();
        set_dest(0, 3'd1, 3'd0);
        set_dest(4, 3'd0, 3'd2);
        in_valid  = 5'b10001;
        out_ready = 5'b0;
        tick();
        checks++;
        if (out_valid !== 5'b01010) begin
            failures++;
            $display("FAIL parallel_out_valid got=%b exp=%b", out_valid, 5'b01010);
        end
        checks++;
        if (sel_of(1) !== 3'd0 || sel_of(3) !== 3'd4) begin
            failures++;
            $display("FAIL parallel_sel got=S%0d/W%0d exp=S%0d/W%0d", sel_of(1), sel_of(3), 0, 4);
        end
        out_ready = 5'b01010;
        #1;
        checks++;
        if (in_ready !== 5'b10001) begin
            failures++;
            $display("FAIL parallel_in_ready got=%b exp=%b", in_ready, 5'b10001);
        end
        tick();
        in_valid  = 5'b0;
        out_ready = 5'b0;
        #1;
        checks++;
        if (out_valid !== 5'b0) begin
            failures++;
            $display("FAIL parallel_release got=%b exp=%b", out_valid, 5'b0);
        end
    endtask

    task automatic test_reset_mid_lock();
        set_dest(0, 3'd3, 3'd1);
        in_valid  = 5'b00001;
        out_ready = 5'b0;
        tick();
        checks++;
        if (out_valid !== 5'b00100) begin
            failures++;
            $display("FAIL midlock_locked got=%b exp=%b", out_valid, 5'b00100);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 5'b0) begin
            failures++;
            $display("FAIL midlock_in_ready_pre got=%b exp=%b", in_ready, 5'b0);
        end
        tick();
        checks++;
        if (out_valid !== 5'b0 || xbar_sel !== 15'h7FFF) begin
            failures++;
            $display("FAIL midlock_reset got=%b/%h exp=%b/%h", out_valid, xbar_sel, 5'b0, 15'h7FFF);
        end
        out_ready = 5'h1F;
        #1;
        checks++;
        if (in_ready !== 5'b0) begin
            failures++;
            $display("FAIL midlock_in_ready got=%b exp=%b", in_ready, 5'b0);
        end
        tick();
        checks++;
        if (out_valid !== 5'b0) begin
            failures++;
            $display("FAIL midlock_held_reset got=%b exp=%b", out_valid, 5'b0);
        end
        in_valid  = 5'b0;
        out_ready = 5'b0;
        rst_n     = 1'b1;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 5'b0;
        out_ready = 5'b0;
        in_dest   = '0;
        for (int i = 0; i < 5; i++) set_dest(i, 3'd1, 3'd1);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_parallel();
        test_reset_mid_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
